// File: rtl/reg_file_8x8_pkg.sv
// Shared definitions for the 8x8 register file.
//   DATA_W    : register / ALU operand width
//   REG_COUNT : number of registers
//   ADDR_W    : register index width (log2 of REG_COUNT)
//   wr_state_e: write-tracking FSM states
package reg_file_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    WRITTEN = 1'b1
  } wr_state_e;

endpackage

// File: rtl/reg_file_8x8_if.sv
// Bus between the ALU/writeback stage and the register file.
//   master: drives write data/address/enable, stall and read addresses;
//           receives read data, valid flags and WRITE_DONE.
//   slave : the register file side.
interface reg_file_8x8_if;
  import reg_file_pkg::*;

  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITEENABLE;
  logic              BUSYWAIT;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] REGOUT1;
  logic [DATA_W-1:0] REGOUT2;
  logic              OUT1VALID;
  logic              OUT2VALID;
  logic              WRITE_DONE;

  modport master (
    output IN, INADDRESS, WRITEENABLE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
    input  REGOUT1, REGOUT2, OUT1VALID, OUT2VALID, WRITE_DONE
  );

  modport slave (
    input  IN, INADDRESS, WRITEENABLE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
    output REGOUT1, REGOUT2, OUT1VALID, OUT2VALID, WRITE_DONE
  );

endinterface

// File: rtl/reg_file_8x8_read_port.sv
// Combinational read port of the register file.
//   rd_addr          : register index to read
//   regs / valid     : storage array and written-since-reset mask
//   wr_en/addr/data  : write accepted this cycle (used for forwarding)
//   rd_data/rd_valid : selected data and valid flag
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
module reg_read_port
  import reg_file_pkg::*;
(
  input  logic [ADDR_W-1:0]                 rd_addr,
  input  logic [REG_COUNT-1:0][DATA_W-1:0]  regs,
  input  logic [REG_COUNT-1:0]              valid,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid
);

`ifdef REG_FILE_BYPASS_EN
  // Forward the value being written so a single-cycle datapath sees it
  // before the capturing edge.
  always_comb begin
    rd_data  = regs[rd_addr];
    rd_valid = valid[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data  = wr_data;
      rd_valid = 1'b1;
    end
  end
`else
  // Pure storage read: no path from write data to the read outputs.
  logic unused_bypass;
  assign unused_bypass = &{1'b0, wr_en, wr_addr, wr_data};

  always_comb begin
    rd_data  = regs[rd_addr];
    rd_valid = valid[rd_addr];
  end
`endif

endmodule

// File: rtl/reg_file_8x8.sv
// Eight-entry, 8-bit register file feeding the ALU operands.
//   CLK     : sole clock, rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : reg_file_8x8_if.slave (write side, stall, two read ports,
//             valid flags, WRITE_DONE)
// A write lands when WRITEENABLE=1 and BUSYWAIT=0 at the rising edge;
// stalled writes are dropped, the producer holds them until BUSYWAIT falls.
// Optional feature macro: REG_FILE_BYPASS_EN (see reg_read_port).
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | no write accepted on the last edge, WRITE_DONE=0
// WRITTEN | a write was accepted on the last edge, WRITE_DONE=1
module reg_file_8x8
  import reg_file_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET_N,
  reg_file_8x8_if.slave  bus
);

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [REG_COUNT-1:0]             valid_q, valid_d;
  wr_state_e                        state_q, state_d;
  logic                             wr_accept;

  // RESET_N qualifies acceptance so forwarding cannot leak data while the
  // file is held in reset.
  assign wr_accept = bus.WRITEENABLE & ~bus.BUSYWAIT & RESET_N;

  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    if (wr_accept) begin
      regs_d[bus.INADDRESS]  = bus.IN;
      valid_d[bus.INADDRESS] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_accept)  state_d = WRITTEN;
      WRITTEN: if (!wr_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_q  <= '0;
      valid_q <= '0;
      state_q <= IDLE;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign bus.WRITE_DONE = (state_q == WRITTEN);

  reg_read_port u_rd1 (
    .rd_addr  (bus.OUT1ADDRESS),
    .regs     (regs_q),
    .valid    (valid_q),
    .wr_en    (wr_accept),
    .wr_addr  (bus.INADDRESS),
    .wr_data  (bus.IN),
    .rd_data  (bus.REGOUT1),
    .rd_valid (bus.OUT1VALID)
  );

  reg_read_port u_rd2 (
    .rd_addr  (bus.OUT2ADDRESS),
    .regs     (regs_q),
    .valid    (valid_q),
    .wr_en    (wr_accept),
    .wr_addr  (bus.INADDRESS),
    .wr_data  (bus.IN),
    .rd_data  (bus.REGOUT2),
    .rd_valid (bus.OUT2VALID)
  );

endmodule
